// File: rtl/register_file_sb_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package register_file_sb_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_CNT_W    = 2;
    localparam int DEF_ZERO_R0  = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// Read/write/reservation bundle of the register file.
interface register_file_sb_if
    import register_file_sb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD
);
    localparam int AW = clog2(NUM_REGS);

    logic                     stall;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     rsv_en;
    logic [AW-1:0]            rsv_addr;
    logic                     err;

    modport master (
        output stall, rd_addr, wr_en, wr_addr, wr_data,
        output rsv_en, rsv_addr,
        input  rd_data, rd_busy, err
    );

    modport slave (
        input  stall, rd_addr, wr_en, wr_addr, wr_data,
        input  rsv_en, rsv_addr,
        output rd_data, rd_busy, err
    );

endinterface

// File: rtl/rf_pending_ctr.sv
// Saturating pending-write counter for one register.
module rf_pending_ctr #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             err
);
    logic [CNT_W-1:0] cnt;

    // inc and dec together cancel; out-of-range steps hold and flag
    always_comb begin
        cnt_nxt = cnt;
        err     = 1'b0;
        if (inc && !dec) begin
            if (cnt == '1) err = 1'b1;
            else cnt_nxt = cnt + 1'b1;
        end else if (dec && !inc) begin
            if (cnt == '0) err = 1'b1;
            else cnt_nxt = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else cnt <= cnt_nxt;
    end

endmodule

// File: rtl/register_file_sb.sv
// Register file with per-register pending-write scoreboard,
// write-to-read bypass and stallable registered read ports.
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int ZERO_R0  = DEF_ZERO_R0
) (
    input logic              clk,
    input logic              reset,
    register_file_sb_if.slave bus
);
    localparam int AW = clog2(NUM_REGS);

    logic [DATA_W-1:0]                regs [NUM_REGS];
    logic [NUM_REGS-1:0][CNT_W-1:0]   cnt_nxt;
    logic [NUM_REGS-1:0]              ctr_err;
    logic [NUM_RD*DATA_W-1:0]         rd_d, rd_q;
    logic [NUM_RD-1:0]                rd_b, busy_q;
    logic                             err_q;
    logic                             wr_ok;

    // r0 is never written, so it stays zero and its counter idle
    assign wr_ok = bus.wr_en &&
                   !((ZERO_R0 != 0) && (bus.wr_addr == '0));

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        localparam bit KILL = (ZERO_R0 != 0) && (g == 0);
        logic inc, dec;
        assign inc = !KILL && bus.rsv_en &&
                     (bus.rsv_addr == AW'(g));
        assign dec = !KILL && bus.wr_en &&
                     (bus.wr_addr == AW'(g));
        rf_pending_ctr #(.CNT_W(CNT_W)) u_ctr (
            .clk     (clk),
            .reset   (reset),
            .inc     (inc),
            .dec     (dec),
            .cnt_nxt (cnt_nxt[g]),
            .err     (ctr_err[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = bus.rd_addr[k*AW +: AW];
        assign rd_d[k*DATA_W +: DATA_W] =
            (wr_ok && bus.wr_addr == ra) ? bus.wr_data : regs[ra];
        assign rd_b[k] = cnt_nxt[ra] != '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q   <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= err_q | (|ctr_err);
            if (!bus.stall) begin
                rd_q   <= rd_d;
                busy_q <= rd_b;
            end
        end
    end

    assign bus.rd_data = rd_q;
    assign bus.rd_busy = busy_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Vector-table bench for register_file_sb with an expected-result queue.
module tb_register_file_sb;

    typedef struct {
        bit          rst, st, we, re;
        logic [4:0]  wa, ra, a0, a1;
        logic [31:0] wd;
        logic [31:0] d0, d1;
        bit          b0, b1, e;
    } vec_t;

    typedef struct {
        logic [31:0] d0, d1;
        bit          b0, b1, e;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    register_file_sb_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) bus ();

    register_file_sb #(
        .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .CNT_W(2), .ZERO_R0(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    vec_t vt[$];
    exp_t sb[$];

    function automatic vec_t mk(bit rst, bit st, bit we, int wa,
                                logic [31:0] wd, bit re, int ra,
                                int a0, int a1, logic [31:0] d0,
                                logic [31:0] d1, bit b0, bit b1, bit e);
        vec_t v;
        v.rst = rst; v.st = st; v.we = we; v.re = re;
        v.wa = 5'(wa); v.ra = 5'(ra); v.a0 = 5'(a0); v.a1 = 5'(a1);
        v.wd = wd; v.d0 = d0; v.d1 = d1;
        v.b0 = b0; v.b1 = b1; v.e = e;
        return v;
    endfunction

    task automatic chk(int idx, string name, logic [31:0] act,
                       logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL v%0d %s: got %h want %h", idx, name, act, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t x;
        vec_t v;
        bus.stall = 0; bus.rd_addr = '0; bus.wr_en = 0;
        bus.wr_addr = '0; bus.wr_data = '0;
        bus.rsv_en = 0; bus.rsv_addr = '0;

        //          rst st we wa wd            re ra a0 a1 d0            d1            b0 b1 e
        vt.push_back(mk(1, 1, 1, 5, 32'd99,       1, 5, 5, 7, 0,            0,            0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0,            1, 5, 5, 0, 0,            0,            1, 0, 0));
        vt.push_back(mk(0, 0, 1, 5, 32'd5,        0, 0, 0, 5, 0,            5,            0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0,            0, 0, 5, 3, 5,            0,            0, 0, 0));
        vt.push_back(mk(0, 0, 1, 7, 32'hDEADBEEF, 1, 7, 7, 7, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0,            1, 3, 3, 7, 0,            32'hDEADBEEF, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0,            1, 3, 3, 7, 0,            32'hDEADBEEF, 1, 0, 0));
        vt.push_back(mk(0, 0, 1, 3, 32'd9,        0, 0, 3, 3, 9,            9,            1, 1, 0));
        vt.push_back(mk(0, 0, 1, 3, 32'hA,        0, 0, 3, 7, 32'hA,        32'hDEADBEEF, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 32'h1234,     0, 0, 0, 0, 0,            0,            0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0,            1, 0, 0, 7, 0,            32'hDEADBEEF, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0, 0, 0,            0,            0, 0, 0));
        vt.push_back(mk(0, 0, 1, 2, 32'd6,        1, 2, 2, 7, 6,            32'hDEADBEEF, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 2, 32'd8,        1, 2, 2, 3, 6,            32'hDEADBEEF, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0,            0, 0, 2, 3, 8,            32'hA,        0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 0,            1, 2, 2, 2, 8,            32'hA,        0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0,            0, 0, 2, 2, 8,            8,            1, 1, 0));
        vt.push_back(mk(0, 0, 1, 2, 32'h55,       0, 0, 2, 0, 32'h55,       0,            0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0,            1, 4, 4, 2, 0,            32'h55,       1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0,            1, 4, 4, 2, 0,            32'h55,       1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0,            1, 4, 4, 2, 0,            32'h55,       1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0,            1, 4, 4, 2, 0,            32'h55,       1, 0, 1));
        vt.push_back(mk(0, 0, 1, 4, 32'd1,        0, 0, 4, 4, 1,            1,            1, 1, 1));
        vt.push_back(mk(0, 0, 1, 4, 32'd2,        0, 0, 4, 4, 2,            2,            1, 1, 1));
        vt.push_back(mk(0, 0, 1, 4, 32'd3,        0, 0, 4, 4, 3,            3,            0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 0,            0, 0, 4, 5, 3,            5,            0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 0,            0, 0, 4, 5, 0,            0,            0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0,            0, 0, 4, 5, 0,            0,            0, 0, 0));
        vt.push_back(mk(0, 0, 1, 6, 32'h77,       0, 0, 6, 6, 32'h77,       32'h77,       0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 0,            1, 9, 6, 9, 32'h77,       0,            0, 1, 1));
        vt.push_back(mk(1, 0, 1, 9, 32'd3,        1, 9, 9, 6, 0,            0,            0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0,            0, 0, 9, 6, 0,            0,            0, 0, 0));

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            v = vt[i];
            reset        = v.rst;
            bus.stall    = v.st;
            bus.wr_en    = v.we;
            bus.wr_addr  = v.wa;
            bus.wr_data  = v.wd;
            bus.rsv_en   = v.re;
            bus.rsv_addr = v.ra;
            bus.rd_addr  = {v.a1, v.a0};
            x.d0 = v.d0; x.d1 = v.d1;
            x.b0 = v.b0; x.b1 = v.b1; x.e = v.e;
            sb.push_back(x);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL v%0d scoreboard: queue empty", i);
            end else begin
                x = sb.pop_front();
                chk(i, "rd_data0", bus.rd_data[31:0], x.d0);
                chk(i, "rd_data1", bus.rd_data[63:32], x.d1);
                chk(i, "rd_busy0", 32'(bus.rd_busy[0]), 32'(x.b0));
                chk(i, "rd_busy1", 32'(bus.rd_busy[1]), 32'(x.b1));
                chk(i, "err", 32'(bus.err), 32'(x.e));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
